blink_event_driver: RTL

- Output-side counterpart to the push-button input path: turns button events back into human-visible LED blinks.
- Input is a toggle-per-event level, one level change per debounced push-release, which is the same encoding the button debouncers produce.
- Each event yields one blink of fixed on-time, followed by a fixed off-gap. Events arriving while a blink is in progress are queued in a saturating pending counter.
- Sits between the debouncers / password logic and the board LEDs.

---
 rtl/blink_event_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/blink_event_driver.sv
// rtl/blink_event_driver.sv - Turns toggle-per-event input into fixed-length LED blinks
//
// Purpose: each level change on ev_tgl queues one blink. A blink is ON_CYC
// cycles of led=1 followed by OFF_CYC cycles of led=0. Events that arrive
// during a blink wait in a saturating pending counter.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ev_tgl   in   event toggle, may be asynchronous to clk
//   ovf_clr  in   one-cycle pulse clearing ovf
//   led      out  blink output, active high
//   busy     out  blink in progress or events pending
//   pend_cnt out  events queued, not yet started
//   ovf      out  sticky dropped-event flag
//
// Optional feature: define BLINK_OVF_FLAG_EN to enable ovf. Without it ovf is
// tied 0 and ovf_clr is ignored; dropping behaviour is the same either way.
module blink_event_driver #(
  parameter int ON_CYC  = 12500000,
  parameter int OFF_CYC = 12500000,
  parameter int PEND_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_tgl,
  input  logic              ovf_clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic [PEND_W-1:0] r_pend;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_evt;
  logic              w_dec;
  logic              w_drop;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_led;
  logic              w_busy;

  // Two-flop synchroniser plus one edge-detect flop. Clearing all three to 0
  // means a high ev_tgl at reset release is seen as exactly one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ev_tgl;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_evt = r_s2 ^ r_s3;

  // An event is lost only when the queue is full and no blink starts now.
  assign w_drop = w_evt && !w_dec && (r_pend == PEND_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (w_evt && !w_dec) begin
      if (r_pend != PEND_MAX) begin
        r_pend <= r_pend + PEND_ONE;
      end
    end else if (w_dec && !w_evt) begin
      r_pend <= r_pend - PEND_ONE;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM: next state. w_dec marks the cycle a queued event becomes a blink;
  // GAP chains straight into ON so back-to-back blinks have no idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != '0) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = ON_LOAD;
          w_dec       = 1'b1;
        end
      end
      ST_ON: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = OFF_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (r_pend != '0) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = ON_LOAD;
          w_dec       = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM: outputs, decoded from registers only so reset clears led at once.
  always_comb begin
    w_led  = (r_state == ST_ON);
    w_busy = (r_state != ST_IDLE) || (r_pend != '0);
  end

  assign led      = w_led;
  assign busy     = w_busy;
  assign pend_cnt = r_pend;

`ifdef BLINK_OVF_FLAG_EN
  logic r_ovf;

  // A drop in the same cycle as ovf_clr wins, so no drop goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf;

  assign w_unused_ovf = ovf_clr ^ w_drop;
  assign ovf          = 1'b0;
`endif

endmodule
